// File: rtl/data_mem_ctrl_if.sv
// External memory handshake bus between the data memory controller and the memory.
interface data_mem_ctrl_if;
    logic        ext_req;
    logic        ext_we;
    logic [29:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [31:0] ext_rdata;
    logic        ext_ack;

    modport master (
        output ext_req,
        output ext_we,
        output ext_addr,
        output ext_wdata,
        input  ext_rdata,
        input  ext_ack
    );

    modport slave (
        input  ext_req,
        input  ext_we,
        input  ext_addr,
        input  ext_wdata,
        output ext_rdata,
        output ext_ack
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory controller: bridges core load/store requests onto a req/ack
// external memory bus, stalling the core until the access retires.
module data_mem_ctrl #(
    parameter logic [7:0] TMO = 8'd200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           add,
    input  logic [31:0]           wd,
    input  logic                  mw,
    input  logic                  mre,
    output logic [31:0]           rd,
    output logic                  stall,
    output logic                  err,
    data_mem_ctrl_if.master       ext
);

    localparam int unsigned DW  = 32;
    localparam int unsigned WAW = 30;
    localparam int unsigned CW  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   rd_d;
    logic            err_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [WAW-1:0]  addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic            access;
    logic            aligned;

    assign access  = mw | mre;
    assign aligned = (add[1:0] == 2'b00);
    assign cnt_inc = CW'(cnt_q + CW'(1));

    assign ext.ext_req   = req_q;
    assign ext.ext_we    = we_q;
    assign ext.ext_addr  = addr_q;
    assign ext.ext_wdata = wdata_q;

    // State and captured access registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd      <= '0;
            err     <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rd      <= rd_d;
            err     <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, capture, timeout and stall decode.
    always_comb begin
        state_d = state_q;
        rd_d    = rd;
        err_d   = err;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (access) begin
                    if (aligned) begin
                        // Store wins when both requests are high.
                        stall   = 1'b1;
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = mw;
                        addr_d  = add[31:2];
                        wdata_d = wd;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (ext.ext_ack) begin
                    // Ack takes priority over a coincident timeout.
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rd_d = ext.ext_rdata;
                    end
                end else if (cnt_inc == TMO) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = cnt_inc;
                    if (!we_q) begin
                        rd_d = '0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized self-checking bench for data_mem_ctrl against a transaction-level model.
module tb_data_mem_ctrl;

    localparam logic [7:0] TMO   = 8'd200;
    localparam int         TMO_I = 200;

    logic        clk;
    logic        rst_n;
    logic [31:0] add;
    logic [31:0] wd;
    logic        mw;
    logic        mre;
    logic [31:0] rd;
    logic        stall;
    logic        err;

    data_mem_ctrl_if bus ();

    data_mem_ctrl #(.TMO(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .add   (add),
        .wd    (wd),
        .mw    (mw),
        .mre   (mre),
        .rd    (rd),
        .stall (stall),
        .err   (err),
        .ext   (bus)
    );

    int          checks;
    int          failures;
    logic [31:0] rd_exp;
    logic        err_exp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One aligned access; lat = REQ cycles before the ack (ack lands in REQ cycle lat+1).
    task automatic do_access(input logic w, input logic r, input logic [31:0] a,
                             input logic [31:0] d, input int lat, input logic [31:0] rdata);
        int   req_cycles   = 0;
        int   stall_cycles = 0;
        bit   done         = 0;
        bit   is_wr        = w;
        bit   timed_out    = (lat + 1 > TMO_I);
        int   exp_req      = timed_out ? TMO_I : lat + 1;
        logic [29:0] exp_addr = a[31:2];
        mw = w; mre = r; add = a; wd = d;
        #1;
        for (int cyc = 0; cyc < TMO_I + 20 && !done; cyc++) begin
            if (stall) begin
                stall_cycles++;
                bus.ext_ack = 1'b0;
                if (bus.ext_req) begin
                    req_cycles++;
                    check("ext_addr", 32'(bus.ext_addr), 32'(exp_addr));
                    check("ext_we", 32'(bus.ext_we), 32'(is_wr));
                    if (is_wr) check("ext_wdata", bus.ext_wdata, d);
                    if (req_cycles == lat + 1) begin
                        bus.ext_ack   = 1'b1;
                        bus.ext_rdata = rdata;
                    end else begin
                        bus.ext_rdata = $urandom;
                    end
                    add = $urandom;
                    wd  = $urandom;
                end
                @(negedge clk); #1;
            end else begin
                done = 1;
            end
        end
        bus.ext_ack = 1'b0;
        check("done_reached", 32'(done), 32'd1);
        if (timed_out) begin
            err_exp = 1'b1;
            if (!is_wr) rd_exp = 32'h0;
        end else if (!is_wr) begin
            rd_exp = rdata;
        end
        check("stall_cycles", 32'(stall_cycles), 32'(1 + exp_req));
        check("req_cycles", 32'(req_cycles), 32'(exp_req));
        check("done_rd", rd, rd_exp);
        check("done_err", 32'(err), 32'(err_exp));
        check("done_req", 32'(bus.ext_req), 32'd0);
        mw = 1'b0; mre = 1'b0;
        @(negedge clk); #1;
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_req", 32'(bus.ext_req), 32'd0);
    endtask

    task automatic do_misaligned(input logic w, input logic r, input logic [31:0] a);
        mw = w; mre = r; add = a; wd = $urandom;
        #1;
        check("mis_stall", 32'(stall), 32'd0);
        check("mis_req0", 32'(bus.ext_req), 32'd0);
        @(negedge clk); #1;
        err_exp = 1'b1;
        check("mis_err", 32'(err), 32'(err_exp));
        check("mis_req1", 32'(bus.ext_req), 32'd0);
        check("mis_rd", rd, rd_exp);
        mw = 1'b0; mre = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic apply_reset();
        mw = 1'b0; mre = 1'b0;
        rst_n = 1'b0;
        #1;
        rd_exp = 32'h0; err_exp = 1'b0;
        check("rst_rd", rd, rd_exp);
        check("rst_err", 32'(err), 32'(err_exp));
        check("rst_req", 32'(bus.ext_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Idle ack pulse must leave every observable untouched.
    task automatic idle_ack();
        bus.ext_ack = 1'b1; bus.ext_rdata = $urandom;
        @(negedge clk);
        bus.ext_ack = 1'b0;
        #1;
        check("idle_ack_rd", rd, rd_exp);
        check("idle_ack_err", 32'(err), 32'(err_exp));
        check("idle_ack_req", 32'(bus.ext_req), 32'd0);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; mw = 1'b0; mre = 1'b0; add = '0; wd = '0;
        bus.ext_ack = 1'b0; bus.ext_rdata = '0;
        rd_exp = '0; err_exp = 1'b0;
        #1;
        check("reset_rd", rd, 32'h0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_req", 32'(bus.ext_req), 32'd0);
        check("reset_we", 32'(bus.ext_we), 32'd0);
        check("reset_addr", 32'(bus.ext_addr), 32'd0);
        check("reset_wdata", bus.ext_wdata, 32'h0);
        check("reset_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        do_access(1'b0, 1'b1, 32'h0000_0040, 32'h0, 0, 32'h1234_5678);
        do_access(1'b1, 1'b0, 32'h0000_0080, 32'hCAFE_F00D, 3, 32'hDEAD_BEEF);
        do_access(1'b1, 1'b1, 32'h0000_0100, 32'h0BAD_CAFE, TMO_I - 1, 32'h5555_AAAA);
        idle_ack();

        // Reset asserted during the second REQ cycle of a read.
        mre = 1'b1; add = 32'h0000_0200;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("mid_req_active", 32'(bus.ext_req), 32'd1);
        rst_n = 1'b0; mre = 1'b0;
        #1;
        rd_exp = 32'h0; err_exp = 1'b0;
        check("mid_rst_req", 32'(bus.ext_req), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_rd", rd, rd_exp);
        check("mid_rst_err", 32'(err), 32'(err_exp));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        idle_ack();

        do_access(1'b0, 1'b1, 32'h0000_0300, 32'h0, TMO_I + 5, 32'h7777_7777);
        do_access(1'b0, 1'b1, 32'h0000_0304, 32'h0, 1, 32'hA5A5_0001);
        apply_reset();
        do_misaligned(1'b0, 1'b1, 32'h0000_0042);
        apply_reset();

        for (int i = 0; i < 40; i++) begin
            int          mode  = $urandom_range(1, 3);
            int          kind  = $urandom_range(0, 19);
            logic [31:0] a     = $urandom & 32'hFFFF_FFFC;
            int          lat   = $urandom_range(0, 6);
            if (kind == 0) begin
                do_misaligned(mode[1], mode[0], a | 32'($urandom_range(1, 3)));
            end else if (kind == 1) begin
                idle_ack();
            end else begin
                if (kind == 2) lat = TMO_I - 1;
                if (kind == 3 && i < 20) lat = TMO_I + 3;
                do_access(mode[1], mode[0], a, $urandom, lat, $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The module SHALL have the parameter TMO, default 8'd200, which is the maximum number of cycles to wait for ext_ack before abort.
REQ-002 The module SHALL have the port clk, input, width 1: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have the port rst_n, input, width 1: asynchronous, active-low reset.
REQ-004 The module SHALL have the port add, input, width 32: the byte address from the core ALU result.
REQ-005 The module SHALL have the port wd, input, width 32: the store data from the core.
REQ-006 The module SHALL have the port mw, input, width 1: the core store request, level-held for the whole instruction.
REQ-007 The module SHALL have the port mre, input, width 1: the core load request, level-held for the whole instruction.
REQ-008 The module SHALL have the port rd, output, width 32: registered load data returned to the core writeback mux.
REQ-009 The module SHALL have the port stall, output, width 1: freezes the core PC and writeback while high.
REQ-010 The module SHALL have the port err, output, width 1: sticky error flag (misaligned address or timeout).
REQ-011 The module SHALL have the port ext_req, output, width 1: external memory request.
REQ-012 The module SHALL have the port ext_we, output, width 1: external write enable, valid while ext_req is high.
REQ-013 The module SHALL have the port ext_addr, output, width 30: external word address, equal to add[31:2] as captured.
REQ-014 The module SHALL have the port ext_wdata, output, width 32: external write data as captured.
REQ-015 The module SHALL have the port ext_rdata, input, width 32: external read data, valid in the cycle ext_ack is high.
REQ-016 The module SHALL have the port ext_ack, input, width 1: single-cycle completion pulse from external memory.

Function
REQ-017 The module SHALL implement an FSM with states IDLE, REQ, DONE.
REQ-018 In IDLE, when (mw|mre) is high and add[1:0]==0, the module SHALL capture add[31:2], wd and the write flag into registers and move to REQ on the next edge.
REQ-019 The stall output SHALL be combinational: high in IDLE while (mw|mre) is high with add aligned, high throughout REQ, and low in DONE.
REQ-020 When mw and mre are both high, the module SHALL treat the access as a write.
REQ-021 In REQ, ext_req SHALL be high, and ext_addr, ext_we and ext_wdata SHALL be driven from the captured registers and held stable until ext_ack.
REQ-022 On ext_ack in REQ, the module SHALL move to DONE; for a read it SHALL load ext_rdata into rd on the same edge, and for a write rd SHALL be unchanged.
REQ-023 In DONE, stall SHALL be low so that the core retires at this edge, and the FSM SHALL return to IDLE on the next edge unconditionally.
REQ-024 Minimum access latency SHALL be 3 cycles (IDLE→REQ→DONE with ext_ack in the first REQ cycle); the core SHALL be stalled for 2 cycles in that case.
REQ-025 An 8-bit wait counter SHALL clear on entry to REQ and increment each REQ cycle without ext_ack.
REQ-026 When the wait counter reaches TMO without ext_ack, the module SHALL drop ext_req, set rd to 32'h0 for a read, set err, and go to DONE.
REQ-027 If ext_ack arrives in the same cycle the count reaches TMO, ext_ack SHALL win: the access completes normally and err is not set.
REQ-028 A misaligned access (add[1:0]!=0 with mw|mre high in IDLE) SHALL issue no ext_req and no stall, SHALL set err, and SHALL leave rd unchanged.
REQ-029 When ext_ack arrives outside REQ, the module SHALL ignore it.
REQ-030 While stall is high, input changes on add, wd, mw and mre SHALL be ignored.
REQ-031 The err flag SHALL clear only on reset.

Reset
REQ-032 While rst_n is low, the module SHALL asynchronously force state IDLE, rd=0, err=0, ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0 and wait counter=0.
REQ-033 An assertion of rst_n mid-access SHALL drop ext_req immediately, and the in-flight access SHALL be discarded without retry.
REQ-034 After rst_n deasserts, the first access SHALL be accepted on the first rising edge at which mw or mre is high.

Verification
REQ-035 Read with immediate ack: mre=1, add=0x40, ext_ack in the first REQ cycle with ext_rdata=0x12345678 -> ext_addr=0x10, stall high for 2 cycles, rd=0x12345678 in DONE, err=0.
REQ-036 Write with 3 wait cycles: mw=1, add=0x80, wd=0xCAFEF00D, ext_ack in the 4th REQ cycle -> ext_we=1 and ext_wdata=0xCAFEF00D stable for 4 cycles, stall high for 5 cycles, rd unchanged.
REQ-037 Timeout: mre=1 with no ext_ack -> ext_req drops after TMO=200 REQ cycles, rd=0, err=1, and the next access still completes normally.
REQ-038 Misaligned access: mre=1, add=0x42 -> no ext_req, stall=0, err=1 on the next edge.
REQ-039 Reset mid-access: rst_n pulsed low in the 2nd REQ cycle -> ext_req=0 immediately, state IDLE, err=0, rd=0, and a later ext_ack is ignored.
REQ-040 Simultaneous mw and mre at add=0x100 -> ext_we=1 (write performed), and ext_ack coinciding with the TMO count gives err=0.
